regfile_operand_stage: RTL and testbench

Operand-fetch stage that sits directly upstream of the 16-bit ripple-carry adder. It holds the architectural register file: 8 x 16-bit registers, with r0 hard-wired to zero. It reads two source registers per issued instruction and presents them on a registered valid/ready output that drives the adder's rb/rc inputs. It also accepts the adder result back through a write-back port, with same-cycle bypass and update of held operands during stalls.

---
 rtl/regfile_operand_stage_pkg.sv | 12 +
 rtl/regfile_2r1w.sv | 49 ++++
 rtl/regfile_operand_stage.sv | 120 ++++++++++++
 tb/tb_regfile_operand_stage.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_operand_stage_pkg.sv
// Shared sizing constants for the operand-fetch stage and its register file.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_operand_stage_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned NREG   = 2 ** ADDR_W;
   // r0 is architecturally hard-wired to zero
   localparam int unsigned R0     = 0;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: 2 read ports + debug read, 1 write port, r0 reads as zero.
// Latency: reads combinational, write lands on the rising edge.
// Backpressure: none; the write port is always accepted.
//
// Ports:
//   clk, rst_n                     clock and async active-low reset (clears all entries)
//   rd0_addr_i/rd0_data_o          read port 0
//   rd1_addr_i/rd1_data_o          read port 1
//   dbg_addr_i/dbg_data_o          debug read port
//   wr_en_i/wr_addr_i/wr_data_i    synchronous write; writes to r0 are dropped
module regfile_2r1w
   import regfile_operand_stage_pkg::*;
#(
   parameter int unsigned DW = DATA_W,
   parameter int unsigned AW = ADDR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] rd0_addr_i,
   output logic [DW-1:0] rd0_data_o,
   input  logic [AW-1:0] rd1_addr_i,
   output logic [DW-1:0] rd1_data_o,
   input  logic [AW-1:0] dbg_addr_i,
   output logic [DW-1:0] dbg_data_o,
   input  logic          wr_en_i,
   input  logic [AW-1:0] wr_addr_i,
   input  logic [DW-1:0] wr_data_i
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(R0);

   logic [DW-1:0] regs_q [2**AW];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2**AW; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en_i && (wr_addr_i != ZERO_ADDR)) begin
         regs_q[wr_addr_i] <= wr_data_i;
      end
   end

   // r0 is forced here as well so the zero never depends on storage contents
   assign rd0_data_o = (rd0_addr_i == ZERO_ADDR) ? '0 : regs_q[rd0_addr_i];
   assign rd1_data_o = (rd1_addr_i == ZERO_ADDR) ? '0 : regs_q[rd1_addr_i];
   assign dbg_data_o = (dbg_addr_i == ZERO_ADDR) ? '0 : regs_q[dbg_addr_i];

endmodule

// File: rtl/regfile_operand_stage.sv
// Operand fetch: reads rb/rc from the register file and presents them registered to the adder.
// Latency: 1 cycle from accept to out_valid; full throughput with back-to-back issues.
// Backpressure: in_ready = !out_valid || out_ready; held operands track write-back while stalled.
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid/in_ready/in_r{a,b,c}_addr  issue handshake with destination and source addresses
//   out_valid/out_ready/out_rb/out_rc/out_ra_addr  registered operand set to the adder
//   wb_en/wb_addr/wb_data               write-back of adder result, never back-pressured
//   dbg_addr/dbg_data                   combinational debug read (pre-write value)
module regfile_operand_stage
   import regfile_operand_stage_pkg::*;
#(
   parameter int unsigned DATA_W = regfile_operand_stage_pkg::DATA_W,
   parameter int unsigned ADDR_W = regfile_operand_stage_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] in_ra_addr,
   input  logic [ADDR_W-1:0] in_rb_addr,
   input  logic [ADDR_W-1:0] in_rc_addr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_rb,
   output logic [DATA_W-1:0] out_rc,
   output logic [ADDR_W-1:0] out_ra_addr,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(R0);

   logic [DATA_W-1:0] rf_rb, rf_rc;
   logic [DATA_W-1:0] opnd_rb, opnd_rc;
   logic              accept;
   logic              wb_live;

   logic              vld_q,  vld_d;
   logic [DATA_W-1:0] rb_q,   rb_d;
   logic [DATA_W-1:0] rc_q,   rc_d;
   logic [ADDR_W-1:0] ra_q,   ra_d;
   logic [ADDR_W-1:0] rb_a_q, rb_a_d;
   logic [ADDR_W-1:0] rc_a_q, rc_a_d;

   regfile_2r1w #(.DW(DATA_W), .AW(ADDR_W)) u_rf (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd0_addr_i (in_rb_addr),
      .rd0_data_o (rf_rb),
      .rd1_addr_i (in_rc_addr),
      .rd1_data_o (rf_rc),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .wr_en_i    (wb_en),
      .wr_addr_i  (wb_addr),
      .wr_data_i  (wb_data)
   );

   assign in_ready = !vld_q || out_ready;
   assign accept   = in_valid && in_ready;
   // a write to r0 is a no-op everywhere, including bypass and stall refresh
   assign wb_live  = wb_en && (wb_addr != ZERO_ADDR);

   // Same-cycle write-back wins over the stored value so the issue sees the newest data
   assign opnd_rb = (wb_live && (wb_addr == in_rb_addr)) ? wb_data : rf_rb;
   assign opnd_rc = (wb_live && (wb_addr == in_rc_addr)) ? wb_data : rf_rc;

   always_comb begin
      vld_d  = vld_q;
      rb_d   = rb_q;
      rc_d   = rc_q;
      ra_d   = ra_q;
      rb_a_d = rb_a_q;
      rc_a_d = rc_a_q;
      if (accept) begin
         vld_d  = 1'b1;
         rb_d   = opnd_rb;
         rc_d   = opnd_rc;
         ra_d   = in_ra_addr;
         rb_a_d = in_rb_addr;
         rc_a_d = in_rc_addr;
      end else if (vld_q && out_ready) begin
         // consumed with nothing behind it: data outputs keep their last value
         vld_d = 1'b0;
      end else if (vld_q) begin
         // stalled: refresh any held operand whose source is being written now
         if (wb_live && (wb_addr == rb_a_q)) rb_d = wb_data;
         if (wb_live && (wb_addr == rc_a_q)) rc_d = wb_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= 1'b0;
         rb_q   <= '0;
         rc_q   <= '0;
         ra_q   <= '0;
         rb_a_q <= '0;
         rc_a_q <= '0;
      end else begin
         vld_q  <= vld_d;
         rb_q   <= rb_d;
         rc_q   <= rc_d;
         ra_q   <= ra_d;
         rb_a_q <= rb_a_d;
         rc_a_q <= rc_a_d;
      end
   end

   assign out_valid   = vld_q;
   assign out_rb      = rb_q;
   assign out_rc      = rc_q;
   assign out_ra_addr = ra_q;

endmodule

// File: tb/tb_regfile_operand_stage.sv
module tb_regfile_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_ra_addr, in_rb_addr, in_rc_addr;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_rb, out_rc;
   logic [2:0]  out_ra_addr;
   logic        wb_en;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic [2:0]  dbg_addr;
   logic [15:0] dbg_data;

   int tests = 0;
   int fails = 0;

   // reference state: what an observer of the architecture expects
   logic [15:0] m_regs [8];
   logic        m_vld;
   logic [15:0] m_rb, m_rc;
   logic [2:0]  m_ra, m_hb, m_hc;

   regfile_operand_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_ra_addr  (in_ra_addr),
      .in_rb_addr  (in_rb_addr),
      .in_rc_addr  (in_rc_addr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rb      (out_rb),
      .out_rc      (out_rc),
      .out_ra_addr (out_ra_addr),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_vld = 1'b0;
      m_rb = 16'h0; m_rc = 16'h0;
      m_ra = 3'd0; m_hb = 3'd0; m_hc = 3'd0;
   endtask

   function automatic logic [15:0] operand(input logic [2:0] a);
      if (a == 3'd0) return 16'h0;
      if (wb_en && wb_addr == a) return wb_data;
      return m_regs[a];
   endfunction

   task automatic idle();
      in_valid = 1'b0; out_ready = 1'b1; wb_en = 1'b0;
      in_ra_addr = 3'd0; in_rb_addr = 3'd0; in_rc_addr = 3'd0;
      wb_addr = 3'd0; wb_data = 16'h0; dbg_addr = 3'd0;
   endtask

   // One clock: check combinational outputs, predict, clock, compare registered outputs.
   task automatic cycle();
      logic        acc;
      logic        n_vld;
      logic [15:0] n_rb, n_rc;
      logic [2:0]  n_ra, n_hb, n_hc;
      #1;
      chk("in_ready", in_ready, !m_vld || out_ready);
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
      acc = in_valid && (!m_vld || out_ready);
      n_vld = m_vld; n_rb = m_rb; n_rc = m_rc; n_ra = m_ra; n_hb = m_hb; n_hc = m_hc;
      if (acc) begin
         n_vld = 1'b1; n_ra = in_ra_addr; n_hb = in_rb_addr; n_hc = in_rc_addr;
         n_rb = operand(in_rb_addr); n_rc = operand(in_rc_addr);
      end else if (m_vld && out_ready) begin
         n_vld = 1'b0;
      end else if (m_vld && wb_en && wb_addr != 3'd0) begin
         if (wb_addr == m_hb) n_rb = wb_data;
         if (wb_addr == m_hc) n_rc = wb_data;
      end
      @(posedge clk);
      if (wb_en && wb_addr != 3'd0) m_regs[wb_addr] = wb_data;
      m_vld = n_vld; m_rb = n_rb; m_rc = n_rc; m_ra = n_ra; m_hb = n_hb; m_hc = n_hc;
      #1;
      chk("out_valid", out_valid, m_vld);
      chk("out_rb", out_rb, m_rb);
      chk("out_rc", out_rc, m_rc);
      chk("out_ra_addr", out_ra_addr, m_ra);
   endtask

   initial begin
      idle();
      m_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_rb", out_rb, 16'h0);
      chk("rst_out_rc", out_rc, 16'h0);
      chk("rst_out_ra", out_ra_addr, 3'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("rst_dbg", dbg_data, 16'h0);
      end
      dbg_addr = 3'd0;

      // issue straight after reset: operands read as zero
      in_valid = 1'b1; in_ra_addr = 3'd2; in_rb_addr = 3'd3; in_rc_addr = 3'd5;
      cycle();
      chk("t1_valid", out_valid, 1'b1);
      chk("t1_rb", out_rb, 16'h0);
      chk("t1_rc", out_rc, 16'h0);
      idle();
      cycle();

      // write then read
      wb_en = 1'b1; wb_addr = 3'd3; wb_data = 16'h1234; cycle();
      wb_addr = 3'd5; wb_data = 16'h00FF; cycle();
      idle();
      in_valid = 1'b1; in_ra_addr = 3'd1; in_rb_addr = 3'd3; in_rc_addr = 3'd5;
      cycle();
      chk("t2_rb", out_rb, 16'h1234);
      chk("t2_rc", out_rc, 16'h00FF);
      chk("t2_ra", out_ra_addr, 3'd1);

      // same-cycle bypass, rb == rc
      in_rb_addr = 3'd2; in_rc_addr = 3'd2; in_ra_addr = 3'd6;
      wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF;
      dbg_addr = 3'd2;
      cycle();
      chk("t3_rb", out_rb, 16'hBEEF);
      chk("t3_rc", out_rc, 16'hBEEF);
      idle();

      // r0 protection
      wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hFFFF; cycle();
      idle();
      in_valid = 1'b1; in_rb_addr = 3'd0; in_rc_addr = 3'd3;
      cycle();
      chk("t4_rb", out_rb, 16'h0);
      idle();
      #1;
      chk("t4_dbg0", dbg_data, 16'h0);
      cycle();

      // stall update of a held operand
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0001; cycle();
      idle();
      out_ready = 1'b0; in_valid = 1'b1; in_rb_addr = 3'd3; in_rc_addr = 3'd4; in_ra_addr = 3'd7;
      cycle();
      chk("t5_rc_old", out_rc, 16'h0001);
      in_rb_addr = 3'd1; in_rc_addr = 3'd1;
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h0A0A;
      cycle();
      chk("t5_rc_new", out_rc, 16'h0A0A);
      chk("t5_rb_kept", out_rb, 16'h1234);
      chk("t5_valid", out_valid, 1'b1);
      chk("t5_in_ready", in_ready, 1'b0);
      idle();
      cycle();
      chk("t5_consumed", out_valid, 1'b0);
      chk("t5_hold_rc", out_rc, 16'h0A0A);

      // back-to-back issues then reset mid-stream
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; out_ready = 1'b1;
         in_ra_addr = 3'(k); in_rb_addr = 3'(k + 2); in_rc_addr = 3'(7 - k);
         cycle();
         chk("t6_b2b_valid", out_valid, 1'b1);
      end
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 1'b0);
      m_reset();
      for (int i = 0; i < 8; i++) begin
         dbg_addr = 3'(i);
         #1;
         chk("t6_rst_dbg", dbg_data, 16'h0);
      end
      idle();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 9) < 6);
         in_ra_addr = 3'($urandom_range(0, 7));
         in_rb_addr = 3'($urandom_range(0, 7));
         in_rc_addr = ($urandom_range(0, 4) == 0) ? in_rb_addr : 3'($urandom_range(0, 7));
         wb_en      = ($urandom_range(0, 1) == 1);
         wb_addr    = 3'($urandom_range(0, 7));
         wb_data    = 16'($urandom());
         dbg_addr   = ($urandom_range(0, 3) == 0) ? wb_addr : 3'($urandom_range(0, 7));
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
